// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector for asynchronous board inputs.
// Each channel has a synchroniser, a selectable edge mode, a re-trigger
// hold-off and a sticky pending flag. Levels present at reset release are
// masked by a short warm-up window so they never report as edges.
module edge_detector_multi #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     signal_in,
    input  logic [2*WIDTH-1:0]   edge_mode,
    input  logic [WIDTH-1:0]     clear_pending,
    output logic [WIDTH-1:0]     edge_detect_pulse,
    output logic [WIDTH-1:0]     event_pending,
    output logic                 any_pending
);

    localparam int HCNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int WARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);
    localparam logic [HCNT_W-1:0] HOLD_INIT = HCNT_W'(HOLDOFF);

    logic [WIDTH-1:0]  sync_p [SYNC_STAGES];
    logic [WIDTH-1:0]  sig_p0;
    logic [WIDTH-1:0]  prev_p1;
    logic [WARM_W-1:0] warm;
    logic [HCNT_W-1:0] hcnt [WIDTH];
    logic [WIDTH-1:0]  fire;

    // Saturating decrement for the warm-up counter.
    function automatic logic [WARM_W-1:0] sat_dec_warm(input logic [WARM_W-1:0] v);
        return (v == '0) ? '0 : v - WARM_W'(1);
    endfunction

    // Saturating decrement for a hold-off counter.
    function automatic logic [HCNT_W-1:0] sat_dec_hold(input logic [HCNT_W-1:0] v);
        return (v == '0) ? '0 : v - HCNT_W'(1);
    endfunction

    // Edge qualification for one channel: 00 off, 01 rise, 10 fall, 11 both.
    function automatic logic qualify(input logic [1:0] mode, input logic s, input logic p);
        logic q;
        case (mode)
            2'b01:   q = s & ~p;
            2'b10:   q = ~s & p;
            2'b11:   q = s ^ p;
            default: q = 1'b0;
        endcase
        return q;
    endfunction

    assign sig_p0 = sync_p[SYNC_STAGES-1];

    // Input synchroniser chain plus the one-cycle delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
            prev_p1 <= '0;
        end else begin
            sync_p[0] <= signal_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
            prev_p1 <= sig_p0;
        end
    end

    // Warm-up window: reloaded by reset, counts down to zero and stays there.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm <= WARM_INIT;
        end else begin
            warm <= sat_dec_warm(warm);
        end
    end

    // A channel fires on a qualified edge once warm-up is over and its hold-off has expired.
    always_comb begin
        fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fire[i] = qualify(edge_mode[2*i +: 2], sig_p0[i], prev_p1[i])
                      && (warm == '0) && (hcnt[i] == '0);
        end
    end

    // Per-channel hold-off: loaded on fire, otherwise counts down; edges seen meanwhile are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (rst) begin
                hcnt[i] <= '0;
            end else if (fire[i]) begin
                hcnt[i] <= HOLD_INIT;
            end else begin
                hcnt[i] <= sat_dec_hold(hcnt[i]);
            end
        end
    end

    // Registered pulse and sticky pending flag; a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_detect_pulse <= '0;
            event_pending     <= '0;
        end else begin
            edge_detect_pulse <= fire;
            event_pending     <= (event_pending & ~clear_pending) | fire;
        end
    end

    assign any_pending = |event_pending;

endmodule
